// File: rtl/latch_pipeline_stage_if.sv
// Bus bundle between a pipeline latch and its neighbours: stall/flush control,
// payload in/out and the performance counters.
interface latch_pipeline_stage_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int STALL_WIDTH = 6,
  parameter int COUNT_WIDTH = 16
);
  logic [STALL_WIDTH-1:0] stall;
  logic                   flush;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_valid;
  logic                   counter_clear;
  logic [COUNT_WIDTH-1:0] hold_count;
  logic [COUNT_WIDTH-1:0] bubble_count;
  logic [COUNT_WIDTH-1:0] flush_count;

  modport master (
    output stall, flush, in_data, in_valid, counter_clear,
    input  out_data, out_valid, hold_count, bubble_count, flush_count
  );

  modport slave (
    input  stall, flush, in_data, in_valid, counter_clear,
    output out_data, out_valid, hold_count, bubble_count, flush_count
  );
endinterface

// File: rtl/latch_pipeline_stage.sv
// Inter-stage pipeline register with stall/bubble/flush handling and
// saturating hold/bubble/flush event counters.
module latch_pipeline_stage #(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    STALL_WIDTH  = 6,
  parameter int                    STAGE        = 2,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = {DATA_WIDTH{1'b0}},
  parameter int                    COUNT_WIDTH  = 16
) (
  input logic                clock,
  input logic                reset,
  latch_pipeline_stage_if.slave bus
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_BUBBLE = 2'd1,
    MODE_HOLD   = 2'd2,
    MODE_FLUSH  = 2'd3
  } mode_t;

  logic                   up;
  logic                   down;
  mode_t                  mode;
  logic [DATA_WIDTH-1:0]  held_data;
  logic                   held_valid;
  logic [COUNT_WIDTH-1:0] hold_cnt;
  logic [COUNT_WIDTH-1:0] bubble_cnt;
  logic [COUNT_WIDTH-1:0] flush_cnt;

  // Clear beats increment; increments stop at all-ones.
  function automatic logic [COUNT_WIDTH-1:0] sat_next(
    input logic [COUNT_WIDTH-1:0] cnt,
    input logic                   hit,
    input logic                   clear
  );
    logic [COUNT_WIDTH-1:0] nxt;
    if (clear) begin
      nxt = {COUNT_WIDTH{1'b0}};
    end else if (hit && (cnt != COUNT_MAX)) begin
      nxt = cnt + COUNT_ONE;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  assign up = bus.stall[STAGE];

  // The last stage has no downstream stall bit.
  generate
    if (STAGE == STALL_WIDTH-1) begin : g_last
      assign down = 1'b0;
    end else begin : g_mid
      assign down = bus.stall[STAGE+1];
    end
  endgenerate

  // Priority decode of the per-edge action; up=0/down=1 falls through to PASS.
  always_comb begin
    mode = MODE_PASS;
    if (bus.flush) begin
      mode = MODE_FLUSH;
    end else if (up && !down) begin
      mode = MODE_BUBBLE;
    end else if (up && down) begin
      mode = MODE_HOLD;
    end else begin
      mode = MODE_PASS;
    end
  end

  // Payload/valid register and event counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_data  <= BUBBLE_VALUE;
      held_valid <= 1'b0;
      hold_cnt   <= {COUNT_WIDTH{1'b0}};
      bubble_cnt <= {COUNT_WIDTH{1'b0}};
      flush_cnt  <= {COUNT_WIDTH{1'b0}};
    end else begin
      case (mode)
        MODE_FLUSH, MODE_BUBBLE: begin
          held_data  <= BUBBLE_VALUE;
          held_valid <= 1'b0;
        end
        MODE_HOLD: begin
          held_data  <= held_data;
          held_valid <= held_valid;
        end
        MODE_PASS: begin
          held_data  <= bus.in_data;
          held_valid <= bus.in_valid;
        end
        default: begin
          held_data  <= BUBBLE_VALUE;
          held_valid <= 1'b0;
        end
      endcase
      hold_cnt   <= sat_next(hold_cnt,   mode == MODE_HOLD,   bus.counter_clear);
      bubble_cnt <= sat_next(bubble_cnt, mode == MODE_BUBBLE, bus.counter_clear);
      flush_cnt  <= sat_next(flush_cnt,  mode == MODE_FLUSH,  bus.counter_clear);
    end
  end

  assign bus.out_data     = held_data;
  assign bus.out_valid    = held_valid;
  assign bus.hold_count   = hold_cnt;
  assign bus.bubble_count = bubble_cnt;
  assign bus.flush_count  = flush_cnt;

  latch_pipeline_stage_checker u_checker (
    .clock (clock),
    .reset (reset),
    .up    (up),
    .down  (down)
  );

endmodule

// Flags a downstream stall without an upstream stall, which the stall
// controller never produces.
module latch_pipeline_stage_checker (
  input logic clock,
  input logic reset,
  input logic up,
  input logic down
);
  stall_contiguous: assert property (@(posedge clock) disable iff (reset) !(down && !up));
endmodule

// File: tb/tb_latch_pipeline_stage.sv
// Randomized and directed bench for latch_pipeline_stage: a mid-pipe instance
// (STAGE=2, 16-bit counters) and a last-stage instance (STAGE=5, 2-bit counters).
module tb_latch_pipeline_stage;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  latch_pipeline_stage_if #(.DATA_WIDTH(64), .STALL_WIDTH(6), .COUNT_WIDTH(16)) ifa ();
  latch_pipeline_stage_if #(.DATA_WIDTH(8),  .STALL_WIDTH(6), .COUNT_WIDTH(2))  ifb ();

  latch_pipeline_stage #(
    .DATA_WIDTH(64), .STALL_WIDTH(6), .STAGE(2),
    .BUBBLE_VALUE(64'h0), .COUNT_WIDTH(16)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa.slave)
  );

  latch_pipeline_stage #(
    .DATA_WIDTH(8), .STALL_WIDTH(6), .STAGE(5),
    .BUBBLE_VALUE(8'hA5), .COUNT_WIDTH(2)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] data;
    bit          valid;
    int          hold;
    int          bub;
    int          fl;
  } ref_t;

  ref_t ma;
  ref_t mb;

  // Behavioural model: classify the edge, then update payload and counters.
  function automatic ref_t ref_step(ref_t s, logic [5:0] stall, int stage, bit flush, bit clr,
                                    logic [63:0] din, bit vin, logic [63:0] bubble, int maxc);
    ref_t r = s;
    bit up   = stall[stage];
    bit down = (stage < 5) ? stall[stage+1] : 1'b0;
    bit is_flush  = flush;
    bit is_bubble = !flush && up && !down;
    bit is_hold   = !flush && up && down;
    if (is_flush || is_bubble) begin
      r.data = bubble; r.valid = 1'b0;
    end else if (!up) begin
      r.data = din; r.valid = vin;
    end
    r.hold = clr ? 0 : (is_hold   ? ((s.hold + 1 > maxc) ? maxc : s.hold + 1) : s.hold);
    r.bub  = clr ? 0 : (is_bubble ? ((s.bub  + 1 > maxc) ? maxc : s.bub  + 1) : s.bub);
    r.fl   = clr ? 0 : (is_flush  ? ((s.fl   + 1 > maxc) ? maxc : s.fl   + 1) : s.fl);
    return r;
  endfunction

  task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_all();
    check_value("a_data",   ifa.out_data,           ma.data);
    check_value("a_valid",  64'(ifa.out_valid),     64'(ma.valid));
    check_value("a_hold",   64'(ifa.hold_count),    64'(ma.hold));
    check_value("a_bubble", 64'(ifa.bubble_count),  64'(ma.bub));
    check_value("a_flush",  64'(ifa.flush_count),   64'(ma.fl));
    check_value("b_data",   64'(ifb.out_data),      mb.data);
    check_value("b_valid",  64'(ifb.out_valid),     64'(mb.valid));
    check_value("b_hold",   64'(ifb.hold_count),    64'(mb.hold));
    check_value("b_bubble", 64'(ifb.bubble_count),  64'(mb.bub));
    check_value("b_flush",  64'(ifb.flush_count),   64'(mb.fl));
  endtask

  task automatic model_reset();
    ma = '{64'h0,  1'b0, 0, 0, 0};
    mb = '{64'hA5, 1'b0, 0, 0, 0};
  endtask

  // One clock edge: advance both models on the applied inputs, then compare.
  task automatic cycle();
    @(posedge clock);
    #1;
    ma = ref_step(ma, ifa.stall, 2, ifa.flush, ifa.counter_clear, ifa.in_data, ifa.in_valid, 64'h0, 65535);
    mb = ref_step(mb, ifb.stall, 5, ifb.flush, ifb.counter_clear, 64'(ifb.in_data), ifb.in_valid, 64'hA5, 3);
    check_all();
  endtask

  task automatic drive_a(input logic [5:0] stall, input bit flush, input logic [63:0] din, input bit vin, input bit clr);
    ifa.stall = stall; ifa.flush = flush; ifa.in_data = din; ifa.in_valid = vin; ifa.counter_clear = clr;
  endtask

  task automatic drive_b(input logic [5:0] stall, input bit flush, input logic [7:0] din, input bit vin, input bit clr);
    ifb.stall = stall; ifb.flush = flush; ifb.in_data = din; ifb.in_valid = vin; ifb.counter_clear = clr;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    drive_a(6'b000000, 1'b0, 64'h0, 1'b0, 1'b0);
    drive_b(6'b000000, 1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    #12;
    check_all();
    reset = 1'b0;

    // PASS with a full payload
    drive_a(6'b000000, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
    drive_b(6'b000000, 1'b0, 8'h3C, 1'b1, 1'b0);
    cycle();
    check_value("pass_data",  ifa.out_data, 64'hDEAD_BEEF_0123_4567);
    check_value("pass_valid", 64'(ifa.out_valid), 64'h1);

    // Mid-cycle reset while out_valid=1 must act before the next edge
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2;
    reset = 1'b0;

    drive_a(6'b000000, 1'b0, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
    cycle();
    drive_a(6'b000111, 1'b0, 64'h5555_6666_7777_8888, 1'b1, 1'b0);
    cycle();
    check_value("bubble_valid", 64'(ifa.out_valid), 64'h0);
    check_value("bubble_data",  ifa.out_data, 64'h0);
    check_value("bubble_cnt",   64'(ifa.bubble_count), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive_a(6'b001111, 1'b0, {$urandom, $urandom}, 1'b1, 1'b0);
      cycle();
    end
    check_value("hold_cnt", 64'(ifa.hold_count), 64'd3);

    // Hold a real payload, then flush over the stall
    drive_a(6'b000000, 1'b0, 64'hCAFE_F00D_0000_0001, 1'b1, 1'b0);
    cycle();
    drive_a(6'b001111, 1'b0, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1, 1'b0);
    cycle();
    check_value("held_data", ifa.out_data, 64'hCAFE_F00D_0000_0001);
    drive_a(6'b001111, 1'b1, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1, 1'b0);
    cycle();
    check_value("flush_valid", 64'(ifa.out_valid), 64'h0);
    check_value("flush_cnt",   64'(ifa.flush_count), 64'd1);
    check_value("flush_hold",  64'(ifa.hold_count), 64'd4);
    drive_a(6'b000000, 1'b0, 64'h0, 1'b0, 1'b0);

    // Last stage: stall[5] alone is a bubble; 2-bit counter saturates
    for (int i = 0; i < 5; i++) begin
      drive_b(6'b100000, 1'b0, 8'(i + 1), 1'b1, 1'b0);
      cycle();
    end
    check_value("sat_bubble", 64'(ifb.bubble_count), 64'd3);
    check_value("last_hold",  64'(ifb.hold_count), 64'd0);
    drive_b(6'b111111, 1'b0, 8'h77, 1'b1, 1'b1);
    cycle();
    check_value("clr_bubble", 64'(ifb.bubble_count), 64'd0);

    // Random traffic; stage-2 stalls stay contiguous from stage 0
    for (int i = 0; i < 400; i++) begin
      drive_a(6'((1 << $urandom_range(0, 6)) - 1), ($urandom_range(0, 7) == 0),
              {$urandom, $urandom}, 1'($urandom), ($urandom_range(0, 31) == 0));
      drive_b(6'($urandom_range(0, 63)), ($urandom_range(0, 7) == 0),
              8'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      cycle();
    end
    check_value("last_hold_end", 64'(ifb.hold_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
